pic_ram_arbiter: RTL and testbench



---
 rtl/pic_mem_pkg.sv | 22 ++
 rtl/burst_addr_gen.sv | 42 ++++
 rtl/pic_ram_arbiter.sv | 129 ++++++++++++
 tb/tb_pic_ram_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_mem_pkg.sv
// Shared types and default sizes for the picture-RAM arbiter slice.
//   arb_state_t : arbiter sequencer states
//   grant_t     : requester identity used for round-robin tie breaking
package pic_mem_pkg;

    localparam int unsigned DEF_ADDR_W    = 16;
    localparam int unsigned DEF_DATA_W    = 32;
    localparam int unsigned DEF_BURST_LEN = 8;

    typedef enum logic [1:0] {
        IDLE,
        CPU_RD,
        DMA_BURST,
        DMA_DRAIN
    } arb_state_t;

    typedef enum logic {
        GNT_CPU,
        GNT_DMA
    } grant_t;

endpackage

// File: rtl/burst_addr_gen.sv
// Burst address generator for readout bursts.
//   load       : capture start_addr; beat 0 is issued from start_addr directly,
//                so the register holds start_addr+1 for beat 1
//   advance    : step to the next beat address (wraps at 2^ADDR_W)
//   addr       : address of the beat issued this cycle (beats 1..BURST_LEN-1)
//   last_issue : current beat is the final one of the burst
module burst_addr_gen
    import pic_mem_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned BURST_LEN = DEF_BURST_LEN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              advance,
    input  logic [ADDR_W-1:0] start_addr,
    output logic [ADDR_W-1:0] addr,
    output logic              last_issue
);

    localparam int unsigned CNT_W = $clog2(BURST_LEN) + 1;

    logic [CNT_W-1:0] cnt_q;

    // Beat address and beat index registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr  <= '0;
            cnt_q <= '0;
        end else if (load) begin
            addr  <= start_addr + ADDR_W'(1);
            cnt_q <= CNT_W'(1);
        end else if (advance) begin
            addr  <= addr + ADDR_W'(1);
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign last_issue = (cnt_q == CNT_W'(BURST_LEN - 1));

endmodule

// File: rtl/pic_ram_arbiter.sv
// Arbiter/sequencer for the single-port picture RAM (1-cycle read latency).
// Memory stage: single reads/writes, stalled via cpu_stall (combinational).
// Readout engine: fixed BURST_LEN read bursts, never interrupted.
//   clk, reset                    : clock, async active-high reset
//   cpu_req/we/addr/wdata         : memory-stage request (level, held until served)
//   cpu_stall, cpu_rvalid/rdata   : pipeline hold, read return
//   dma_req/addr                  : burst request (level, address stable while high)
//   dma_rvalid/rdata, dma_done    : burst beat return, last-beat pulse
//   ram_en/we/addr/wdata, ram_rdata : RAM macro port
module pic_ram_arbiter
    import pic_mem_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned BURST_LEN = DEF_BURST_LEN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_addr,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_done,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    arb_state_t        state_q, state_d;
    grant_t            last_q, last_d;
    logic              gen_load, gen_adv, gen_last;
    logic [ADDR_W-1:0] gen_addr;

    burst_addr_gen #(
        .ADDR_W    (ADDR_W),
        .BURST_LEN (BURST_LEN)
    ) u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .load       (gen_load),
        .advance    (gen_adv),
        .start_addr (dma_addr),
        .addr       (gen_addr),
        .last_issue (gen_last)
    );

    // State, round-robin flag and return strobes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            last_q     <= GNT_DMA;
            cpu_rvalid <= 1'b0;
            dma_rvalid <= 1'b0;
            dma_done   <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            cpu_rvalid <= (state_d == CPU_RD);
            dma_rvalid <= (state_d == DMA_BURST) || (state_d == DMA_DRAIN);
            dma_done   <= (state_d == DMA_DRAIN);
        end
    end

    // Arbitration, RAM port steering and next state
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        gen_load  = 1'b0;
        gen_adv   = 1'b0;
        cpu_stall = cpu_req;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        case (state_q)
            IDLE: begin
                // Grants are suppressed while reset is held so the RAM stays quiet
                if (!reset) begin
                    if (cpu_req && (!dma_req || last_q == GNT_DMA)) begin
                        ram_en    = 1'b1;
                        ram_we    = cpu_we;
                        cpu_stall = !cpu_we;
                        if (cpu_we) begin
                            last_d = GNT_CPU;
                        end else begin
                            state_d = CPU_RD;
                        end
                    end else if (dma_req) begin
                        ram_en   = 1'b1;
                        ram_addr = dma_addr;
                        gen_load = 1'b1;
                        state_d  = DMA_BURST;
                    end
                end
            end
            CPU_RD: begin
                cpu_stall = 1'b0;
                last_d    = GNT_CPU;
                state_d   = IDLE;
            end
            DMA_BURST: begin
                ram_en   = 1'b1;
                ram_addr = gen_addr;
                gen_adv  = 1'b1;
                if (gen_last) begin
                    state_d = DMA_DRAIN;
                end
            end
            DMA_DRAIN: begin
                last_d  = GNT_DMA;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cpu_rdata = ram_rdata;
    assign dma_rdata = ram_rdata;

endmodule

// File: tb/tb_pic_ram_arbiter.sv
// Self-checking bench for pic_ram_arbiter: table vectors, directed sequences,
// and randomized traffic against a cycle-schedule reference model.
module tb_pic_ram_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int BL = 8;
    localparam int SZ = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we, cpu_stall, cpu_rvalid;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          dma_req, dma_rvalid, dma_done;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_rdata;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;

    logic [DW-1:0] mem     [0:65535];
    logic [DW-1:0] ref_mem [0:65535];

    int n_checks = 0;
    int n_errors = 0;

    // Cycle-indexed expectation schedule (ring of SZ slots)
    bit            s_en  [SZ];
    bit            s_we  [SZ];
    logic [AW-1:0] s_addr[SZ];
    logic [DW-1:0] s_wd  [SZ];
    bit            s_ok  [SZ];
    bit            s_crv [SZ];
    logic [DW-1:0] s_cd  [SZ];
    bit            s_drv [SZ];
    logic [DW-1:0] s_dd  [SZ];
    bit            s_done[SZ];

    typedef struct {
        logic          rst;
        logic          creq;
        logic          cwe;
        logic          dreq;
        logic          stall;
        logic          en;
        logic          we;
        logic [AW-1:0] addr;
    } vec_t;

    always #5 clk = ~clk;

    pic_ram_arbiter #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .BURST_LEN (BL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_stall  (cpu_stall),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dma_req    (dma_req),
        .dma_addr   (dma_addr),
        .dma_rvalid (dma_rvalid),
        .dma_rdata  (dma_rdata),
        .dma_done   (dma_done),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    // RAM macro: synchronous read, one-cycle latency
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        cpu_req = 1'b0;
        dma_req = 1'b0;
        #1;
        chk("rst_ram_en", ram_en, 1'b0);
        chk("rst_ram_we", ram_we, 1'b0);
        chk("rst_cpu_rvalid", cpu_rvalid, 1'b0);
        chk("rst_dma_rvalid", dma_rvalid, 1'b0);
        chk("rst_dma_done", dma_done, 1'b0);
        chk("rst_cpu_stall", cpu_stall, 1'b0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_burst(input logic [AW-1:0] a, input int abort_k);
        logic [AW-1:0] b;
        @(negedge clk);
        cpu_req  = 1'b0;
        dma_req  = 1'b1;
        dma_addr = a;
        #1;
        chk("burst_t0_en", ram_en, 1'b1);
        chk("burst_t0_we", ram_we, 1'b0);
        chk("burst_t0_addr", ram_addr, a);
        chk("burst_t0_rvalid", dma_rvalid, 1'b0);
        for (int k = 1; k <= BL; k++) begin
            @(negedge clk);
            if (k == BL) dma_req = 1'b0;
            #1;
            b = a + AW'(k - 1);
            chk($sformatf("burst_rvalid_%0d", k), dma_rvalid, 1'b1);
            chk($sformatf("burst_rdata_%0d", k), dma_rdata, ref_mem[b]);
            chk($sformatf("burst_done_%0d", k), dma_done, k == BL);
            chk($sformatf("burst_en_%0d", k), ram_en, k < BL);
            if (k < BL) begin
                b = a + AW'(k);
                chk($sformatf("burst_addr_%0d", k), ram_addr, b);
            end
            if (k == abort_k) begin
                reset   = 1'b1;
                dma_req = 1'b0;
                #1;
                chk("abort_rvalid", dma_rvalid, 1'b0);
                chk("abort_done", dma_done, 1'b0);
                chk("abort_en", ram_en, 1'b0);
                @(negedge clk);
                #1;
                chk("abort_hold_done", dma_done, 1'b0);
                chk("abort_hold_rvalid", dma_rvalid, 1'b0);
                chk("abort_hold_en", ram_en, 1'b0);
                reset = 1'b0;
                @(negedge clk);
                #1;
                chk("abort_idle_en", ram_en, 1'b0);
                chk("abort_idle_rvalid", dma_rvalid, 1'b0);
                return;
            end
        end
        @(negedge clk);
        #1;
        chk("burst_after_en", ram_en, 1'b0);
        chk("burst_after_rvalid", dma_rvalid, 1'b0);
        chk("burst_after_done", dma_done, 1'b0);
    endtask

    // Randomized traffic; expectations are scheduled per cycle from the
    // arbitration rules (grant cost, round-robin on ties, fixed latencies).
    task automatic rand_phase(input int ncyc, input int p_cpu, input int p_dma);
        int free_at, cpu_end, dma_end, sl, sl2;
        bit cpu_pend, dma_pend, lg_dma;
        logic [AW-1:0] a;
        do_reset();
        for (int i = 0; i < SZ; i++) begin
            s_en[i] = 0; s_we[i] = 0; s_ok[i] = 0; s_crv[i] = 0;
            s_drv[i] = 0; s_done[i] = 0;
        end
        free_at = 0; cpu_end = 0; dma_end = 0;
        cpu_pend = 0; dma_pend = 0; lg_dma = 1;
        for (int t = 0; t < ncyc; t++) begin
            @(negedge clk);
            if (cpu_pend && t > cpu_end) cpu_pend = 0;
            if (dma_pend && t > dma_end) dma_pend = 0;
            if (!cpu_pend && int'($urandom_range(99)) < p_cpu) begin
                cpu_pend  = 1;
                cpu_end   = ncyc + 100;
                cpu_we    = 1'($urandom_range(1));
                cpu_addr  = AW'($urandom_range(63));
                cpu_wdata = $urandom;
            end
            if (!dma_pend && int'($urandom_range(99)) < p_dma) begin
                dma_pend = 1;
                dma_end  = ncyc + 100;
                if (!dma_req)
                    dma_addr = ($urandom_range(3) == 0) ? AW'(16'hFFF8 + $urandom_range(7))
                                                        : AW'($urandom_range(63));
            end
            cpu_req = cpu_pend;
            dma_req = dma_pend;
            if (t >= free_at && (cpu_pend || dma_pend)) begin
                if (cpu_pend && (!dma_pend || lg_dma)) begin
                    sl = t % SZ;
                    s_en[sl] = 1; s_we[sl] = cpu_we; s_addr[sl] = cpu_addr; s_wd[sl] = cpu_wdata;
                    lg_dma = 0;
                    if (cpu_we) begin
                        s_ok[sl] = 1;
                        ref_mem[cpu_addr] = cpu_wdata;
                        cpu_end = t;
                        free_at = t + 1;
                    end else begin
                        sl2 = (t + 1) % SZ;
                        s_ok[sl2] = 1; s_crv[sl2] = 1; s_cd[sl2] = ref_mem[cpu_addr];
                        cpu_end = t + 1;
                        free_at = t + 2;
                    end
                end else begin
                    for (int k = 0; k < BL; k++) begin
                        a   = dma_addr + AW'(k);
                        sl  = (t + k) % SZ;
                        sl2 = (t + k + 1) % SZ;
                        s_en[sl] = 1; s_we[sl] = 0; s_addr[sl] = a;
                        s_drv[sl2] = 1; s_dd[sl2] = ref_mem[a];
                    end
                    s_done[(t + BL) % SZ] = 1;
                    dma_end = t + BL;
                    free_at = t + BL + 1;
                    lg_dma  = 1;
                end
            end
            sl = t % SZ;
            #1;
            chk($sformatf("r_stall@%0d", t), cpu_stall, cpu_req && !s_ok[sl]);
            chk($sformatf("r_en@%0d", t), ram_en, s_en[sl]);
            if (s_en[sl]) begin
                chk($sformatf("r_we@%0d", t), ram_we, s_we[sl]);
                chk($sformatf("r_addr@%0d", t), ram_addr, s_addr[sl]);
                if (s_we[sl]) chk($sformatf("r_wdata@%0d", t), ram_wdata, s_wd[sl]);
            end
            chk($sformatf("r_cpu_rvalid@%0d", t), cpu_rvalid, s_crv[sl]);
            if (s_crv[sl]) chk($sformatf("r_cpu_rdata@%0d", t), cpu_rdata, s_cd[sl]);
            chk($sformatf("r_dma_rvalid@%0d", t), dma_rvalid, s_drv[sl]);
            if (s_drv[sl]) chk($sformatf("r_dma_rdata@%0d", t), dma_rdata, s_dd[sl]);
            chk($sformatf("r_dma_done@%0d", t), dma_done, s_done[sl]);
            s_en[sl] = 0; s_we[sl] = 0; s_ok[sl] = 0; s_crv[sl] = 0;
            s_drv[sl] = 0; s_done[sl] = 0;
        end
        @(negedge clk);
        cpu_req = 1'b0;
        dma_req = 1'b0;
    endtask

    initial begin
        vec_t vecs[8];
        reset     = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        dma_req   = 1'b0;
        dma_addr  = '0;
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 32'(i);
            ref_mem[i] = 32'(i);
        end
        @(negedge clk);
        reset = 1'b0;
        do_reset();

        // IDLE arbitration with last_grant at its reset value (DMA)
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0044};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0044};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0500};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0044};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0044};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0500};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            reset    = vecs[i].rst;
            cpu_req  = vecs[i].creq;
            cpu_we   = vecs[i].cwe;
            dma_req  = vecs[i].dreq;
            cpu_addr = 16'h0044;
            dma_addr = 16'h0500;
            #1;
            chk($sformatf("vec%0d_stall", i), cpu_stall, vecs[i].stall);
            chk($sformatf("vec%0d_en", i), ram_en, vecs[i].en);
            chk($sformatf("vec%0d_we", i), ram_we, vecs[i].we);
            if (vecs[i].en) chk($sformatf("vec%0d_addr", i), ram_addr, vecs[i].addr);
            #1;
            reset   = 1'b0;
            cpu_req = 1'b0;
            dma_req = 1'b0;
        end

        // CPU write then read-back; request dropped during CPU_RD
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 32'hDEADBEEF;
        #1;
        chk("wr_en", ram_en, 1'b1);
        chk("wr_we", ram_we, 1'b1);
        chk("wr_addr", ram_addr, 16'h0010);
        chk("wr_wdata", ram_wdata, 32'hDEADBEEF);
        chk("wr_stall", cpu_stall, 1'b0);
        ref_mem[16'h0010] = 32'hDEADBEEF;
        @(negedge clk);
        cpu_we = 1'b0;
        #1;
        chk("rd_stall", cpu_stall, 1'b1);
        chk("rd_en", ram_en, 1'b1);
        chk("rd_we", ram_we, 1'b0);
        chk("rd_addr", ram_addr, 16'h0010);
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        chk("rd_rvalid", cpu_rvalid, 1'b1);
        chk("rd_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("rd_stall_done", cpu_stall, 1'b0);
        chk("rd_en_done", ram_en, 1'b0);
        @(negedge clk);
        #1;
        chk("rd_rvalid_off", cpu_rvalid, 1'b0);

        run_burst(16'h0100, -1);

        // Simultaneous requests after reset, then CPU write held off by a burst
        do_reset();
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0020;
        dma_req = 1'b1; dma_addr = 16'h0200;
        #1;
        chk("tie_stall", cpu_stall, 1'b1);
        chk("tie_en", ram_en, 1'b1);
        chk("tie_addr", ram_addr, 16'h0020);
        @(negedge clk);
        #1;
        chk("tie_rvalid", cpu_rvalid, 1'b1);
        chk("tie_rdata", cpu_rdata, ref_mem[16'h0020]);
        chk("tie_en_rd", ram_en, 1'b0);
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        chk("tie_dma_en", ram_en, 1'b1);
        chk("tie_dma_addr", ram_addr, 16'h0200);
        for (int k = 1; k <= BL; k++) begin
            @(negedge clk);
            if (k == 3) begin
                cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0030; cpu_wdata = 32'h12345678;
            end
            if (k == BL) dma_req = 1'b0;
            #1;
            if (k >= 3) chk($sformatf("held_stall_%0d", k), cpu_stall, 1'b1);
            chk($sformatf("held_rvalid_%0d", k), dma_rvalid, 1'b1);
            chk($sformatf("held_rdata_%0d", k), dma_rdata, 32'h0200 + 32'(k - 1));
        end
        @(negedge clk);
        #1;
        chk("held_serve_stall", cpu_stall, 1'b0);
        chk("held_serve_we", ram_we, 1'b1);
        chk("held_serve_addr", ram_addr, 16'h0030);
        chk("held_serve_wdata", ram_wdata, 32'h12345678);
        ref_mem[16'h0030] = 32'h12345678;
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        chk("held_after_en", ram_en, 1'b0);

        run_burst(16'hFFFE, -1);
        run_burst(16'h0040, 3);
        run_burst(16'h0048, -1);

        rand_phase(500, 30, 20);
        rand_phase(80, 100, 100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
